// File: rtl/csr_access_sequencer_if.sv
// Request/response handshake plus CSR-file read/write ports of the CSR access sequencer.
interface csr_access_sequencer_if #(
    parameter int FFLAGS_WIDTH = 5
);
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [11:0]             req_csr;
    logic [31:0]             req_src;
    logic                    req_rd_zero;
    logic                    req_src_zero;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [31:0]             resp_data;
    logic                    resp_illegal;

    logic                    fflags_valid;
    logic [FFLAGS_WIDTH-1:0] fflags;

    logic                    csr_rd_en;
    logic [11:0]             csr_rd_sel;
    logic [31:0]             csr_rd_data;
    logic [31:0]             fcsr_rd_data;
    logic                    csr_wr_en;
    logic [11:0]             csr_wr_sel;
    logic [31:0]             csr_wr_data;
    logic                    fcsr_wr_en;
    logic [31:0]             fcsr_wr_data;

    modport slave (
        input  req_valid, req_op, req_csr, req_src, req_rd_zero, req_src_zero,
        input  resp_ready, fflags_valid, fflags, csr_rd_data, fcsr_rd_data,
        output req_ready, resp_valid, resp_data, resp_illegal,
        output csr_rd_en, csr_rd_sel, csr_wr_en, csr_wr_sel, csr_wr_data,
        output fcsr_wr_en, fcsr_wr_data
    );

    modport master (
        output req_valid, req_op, req_csr, req_src, req_rd_zero, req_src_zero,
        output resp_ready, fflags_valid, fflags, csr_rd_data, fcsr_rd_data,
        input  req_ready, resp_valid, resp_data, resp_illegal,
        input  csr_rd_en, csr_rd_sel, csr_wr_en, csr_wr_sel, csr_wr_data,
        input  fcsr_wr_en, fcsr_wr_data
    );
endinterface

// File: rtl/csr_access_sequencer.sv
// Sequences CSRRW/CSRRS/CSRRC into read, modify-write and response phases; merges FPU flags into fcsr.
// Latency: response 1-3 cycles after accept (illegal / single-phase / read+write), plus one IDLE between requests.
// Backpressure: req_ready drops while an operation or flag flush is in flight; RESP holds until resp_ready.
module csr_access_sequencer #(
    parameter int FCSR_INDEX   = 3,
    parameter int FFLAGS_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    csr_access_sequencer_if.slave bus
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FLUSH,
        ST_RESP
    } state_e;

    if (FCSR_INDEX < 0 || FCSR_INDEX > 4095) begin : g_bad_fcsr_index
        $error("FCSR_INDEX must fit the 12-bit CSR address space");
    end

    state_e                  state_q, state_d;
    logic [FFLAGS_WIDTH-1:0] pending_q, pending_d;
    logic [FFLAGS_WIDTH-1:0] flag_in;
    logic [1:0]              op_q, op_d;
    logic [11:0]             csr_q, csr_d;
    logic [31:0]             src_q, src_d;
    logic [31:0]             old_q, old_d;
    logic                    src_zero_q, src_zero_d;
    logic                    illegal_q, illegal_d;
    logic [31:0]             wr_val;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            op_q       <= '0;
            csr_q      <= '0;
            src_q      <= '0;
            old_q      <= '0;
            src_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            op_q       <= op_d;
            csr_q      <= csr_d;
            src_q      <= src_d;
            old_q      <= old_d;
            src_zero_q <= src_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign flag_in = bus.fflags_valid ? bus.fflags : '0;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | flag_in;
        op_d       = op_q;
        csr_d      = csr_q;
        src_d      = src_q;
        old_d      = old_q;
        src_zero_d = src_zero_q;
        illegal_d  = illegal_q;
        case (state_q)
            ST_IDLE: begin
                // Pending flags win over a new request so fcsr is current before the next read.
                if (pending_q != '0) begin
                    state_d = ST_FLUSH;
                end else if (bus.req_valid) begin
                    op_d       = bus.req_op;
                    csr_d      = bus.req_csr;
                    src_d      = bus.req_src;
                    src_zero_d = bus.req_src_zero;
                    old_d      = '0;
                    illegal_d  = (bus.req_op == 2'b00);
                    if (bus.req_op == 2'b00) begin
                        state_d = ST_RESP;
                    end else if (bus.req_op == OP_RW && bus.req_rd_zero) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                old_d = bus.csr_rd_data;
                if ((op_q == OP_RS || op_q == OP_RC) && src_zero_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Flags landing during the flush miss this merge and stay pending.
                pending_d = flag_in;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_val = '0;
        case (op_q)
            OP_RW:   wr_val = src_q;
            OP_RS:   wr_val = old_q | src_q;
            OP_RC:   wr_val = old_q & ~src_q;
            default: wr_val = '0;
        endcase
    end

    assign bus.req_ready    = RESET && (state_q == ST_IDLE) && (pending_q == '0);
    assign bus.resp_valid   = (state_q == ST_RESP);
    assign bus.resp_data    = (state_q == ST_RESP) ? old_q : '0;
    assign bus.resp_illegal = (state_q == ST_RESP) && illegal_q;

    assign bus.csr_rd_en    = (state_q == ST_READ);
    assign bus.csr_rd_sel   = (state_q == ST_READ) ? csr_q : '0;
    assign bus.csr_wr_en    = (state_q == ST_WRITE);
    assign bus.csr_wr_sel   = (state_q == ST_WRITE) ? csr_q : '0;
    assign bus.csr_wr_data  = (state_q == ST_WRITE) ? wr_val : '0;

    assign bus.fcsr_wr_en   = (state_q == ST_FLUSH);
    assign bus.fcsr_wr_data = (state_q == ST_FLUSH) ?
                              (bus.fcsr_rd_data | {{(32-FFLAGS_WIDTH){1'b0}}, pending_q}) : '0;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Randomized bench for csr_access_sequencer with a transaction-level reference model and a bench-owned CSR file.
module tb_csr_access_sequencer;

    localparam logic [11:0] FCSR = 12'h003;
    localparam byte PH_R = 8'd1;
    localparam byte PH_W = 8'd2;
    localparam byte PH_P = 8'd3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    csr_access_sequencer_if bus ();

    csr_access_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bench-owned CSR file: combinational read, write on the rising edge; fcsr lives at address 3.
    bit [31:0]   file_mem [4096];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_val;

    assign bus.csr_rd_data  = file_mem[bus.csr_rd_sel];
    assign bus.fcsr_rd_data = file_mem[FCSR];

    always @(posedge CLK) begin
        if (pl_en) begin
            file_mem[pl_addr] <= pl_val;
        end else begin
            if (bus.csr_wr_en)  file_mem[bus.csr_wr_sel] <= bus.csr_wr_data;
            if (bus.fcsr_wr_en) file_mem[FCSR] <= bus.fcsr_wr_data;
        end
    end

    // Reference model state
    bit [31:0]   ref_mem [4096];
    byte         phq [$];
    logic [11:0] cur_csr;
    logic [31:0] cur_wd, cur_resp;
    logic        cur_ill;
    logic [4:0]  mdl_pending;
    logic        flush_due;

    // Raw observations used by the directed checks
    int          cyc = 0, acc_cyc = 0, resp_lat = 0;
    bit          resp_seen;
    int          raw_rd = 0, raw_wr = 0, raw_fl = 0, resp_cnt = 0;
    logic [31:0] last_wr, last_resp;
    logic        last_ill;

    function automatic logic [127:0] outs();
        return {2'b00, bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_illegal,
                bus.csr_rd_en, bus.csr_rd_sel, bus.csr_wr_en, bus.csr_wr_sel, bus.csr_wr_data,
                bus.fcsr_wr_en, bus.fcsr_wr_data};
    endfunction

    always @(negedge CLK) begin : compare
        byte        ph;
        logic       idle_now, next_flush;
        logic [1:0] op;
        logic [31:0] old;
        cyc++;
        if (bus.csr_rd_en)  raw_rd++;
        if (bus.csr_wr_en)  begin raw_wr++; last_wr = bus.csr_wr_data; end
        if (bus.fcsr_wr_en) raw_fl++;
        if (bus.resp_valid && !resp_seen) begin resp_lat = cyc - acc_cyc; resp_seen = 1'b1; end
        if (bus.resp_valid && bus.resp_ready) begin
            resp_cnt++; last_resp = bus.resp_data; last_ill = bus.resp_illegal;
        end
        if (!RESET) begin
            phq.delete();
            mdl_pending = '0;
            flush_due   = 1'b0;
        end else begin
            idle_now = (phq.size() == 0) && !flush_due;
            chk("no_dual_write", bus.csr_wr_en & bus.fcsr_wr_en, 0);
            chk("fcsr_wr_en", bus.fcsr_wr_en, flush_due);
            if (flush_due) begin
                chk("fcsr_wr_data", bus.fcsr_wr_data, ref_mem[FCSR] | {27'b0, mdl_pending});
                ref_mem[FCSR] = ref_mem[FCSR] | {27'b0, mdl_pending};
            end
            chk("req_ready", bus.req_ready, idle_now && (mdl_pending == 0));
            if (phq.size() != 0) begin
                ph = phq[0];
                chk("csr_rd_en", bus.csr_rd_en, ph == PH_R);
                chk("csr_wr_en", bus.csr_wr_en, ph == PH_W);
                chk("resp_valid", bus.resp_valid, ph == PH_P);
                if (ph == PH_R) chk("csr_rd_sel", bus.csr_rd_sel, cur_csr);
                if (ph == PH_W) begin
                    chk("csr_wr_sel", bus.csr_wr_sel, cur_csr);
                    chk("csr_wr_data", bus.csr_wr_data, cur_wd);
                    ref_mem[cur_csr] = cur_wd;
                end
                if (ph == PH_P) begin
                    chk("resp_data", bus.resp_data, cur_resp);
                    chk("resp_illegal", bus.resp_illegal, cur_ill);
                end
                if (ph != PH_P || bus.resp_ready) void'(phq.pop_front());
            end else begin
                chk("idle_rd_en", bus.csr_rd_en, 0);
                chk("idle_wr_en", bus.csr_wr_en, 0);
                chk("idle_resp_valid", bus.resp_valid, 0);
            end
            if (pl_en) ref_mem[pl_addr] = pl_val;
            next_flush  = idle_now && (mdl_pending != 0);
            mdl_pending = (flush_due ? 5'd0 : mdl_pending) | (bus.fflags_valid ? bus.fflags : 5'd0);
            flush_due   = next_flush;
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc   = cyc;
                resp_seen = 1'b0;
                op        = bus.req_op;
                old       = ref_mem[bus.req_csr];
                cur_csr   = bus.req_csr;
                cur_ill   = 1'b0;
                cur_wd    = '0;
                phq.delete();
                if (op == 2'b00) begin
                    cur_resp = '0; cur_ill = 1'b1;
                    phq.push_back(PH_P);
                end else if (op == 2'b01 && bus.req_rd_zero) begin
                    cur_resp = '0; cur_wd = bus.req_src;
                    phq.push_back(PH_W); phq.push_back(PH_P);
                end else if (op != 2'b01 && bus.req_src_zero) begin
                    cur_resp = old;
                    phq.push_back(PH_R); phq.push_back(PH_P);
                end else begin
                    cur_resp = old;
                    cur_wd = (op == 2'b01) ? bus.req_src :
                             (op == 2'b10) ? (old | bus.req_src) : (old & ~bus.req_src);
                    phq.push_back(PH_R); phq.push_back(PH_W); phq.push_back(PH_P);
                end
            end
        end
    end

    int rr_mode;  // 0 random, 1 always ready, 2 never ready
    bit flag_en;

    task automatic tick();
        @(posedge CLK);
        #1;
        bus.resp_ready = (rr_mode == 0) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
        if (flag_en) begin
            bus.fflags_valid = ($urandom_range(0, 9) == 0);
            bus.fflags       = 5'($urandom);
        end else begin
            bus.fflags_valid = 1'b0;
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        pl_addr = a; pl_val = v; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                            input logic rdz, input logic srz);
        int n;
        tick();
        bus.req_op = op; bus.req_csr = a; bus.req_src = s;
        bus.req_rd_zero = rdz; bus.req_src_zero = srz; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("accept_timeout", 0, 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                          input logic rdz, input logic srz);
        int n, start;
        start = resp_cnt;
        send_req(op, a, s, rdz, srz);
        n = 0;
        while (resp_cnt == start && n < 50) begin tick(); n++; end
        chk("resp_timeout", resp_cnt != start, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [11:0] addrs [5];
    int b_rd, b_wr, b_fl;

    initial begin : stim
        addrs[0] = 12'h340; addrs[1] = 12'h300; addrs[2] = FCSR; addrs[3] = 12'h001; addrs[4] = 12'hC00;
        rr_mode = 1; flag_en = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_val = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_csr = '0; bus.req_src = '0;
        bus.req_rd_zero = 1'b0; bus.req_src_zero = 1'b0; bus.resp_ready = 1'b0;
        bus.fflags_valid = 1'b0; bus.fflags = '0;
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #1 chk("reset_outputs", outs(), 0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        // RW with read: write src, return old value three cycles after accept
        preload(12'h340, 32'h12345678);
        b_rd = raw_rd;
        do_txn(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("rw_wr_data", last_wr, 32'hDEADBEEF);
        chk("rw_resp", last_resp, 32'h12345678);
        chk("rw_latency", resp_lat, 3);
        chk("rw_one_read", raw_rd - b_rd, 1);
        tick();
        chk("rw_csr_value", file_mem[12'h340], 32'hDEADBEEF);

        // RS then RC
        preload(12'h300, 32'h3);
        do_txn(2'b10, 12'h300, 32'h8, 1'b0, 1'b0);
        chk("rs_wr_data", last_wr, 32'hB);
        chk("rs_resp", last_resp, 32'h3);
        do_txn(2'b11, 12'h300, 32'h1, 1'b0, 1'b0);
        chk("rc_wr_data", last_wr, 32'hA);
        chk("rc_resp", last_resp, 32'hB);

        // RS with zero source skips the write; RW to x0 skips the read
        b_wr = raw_wr;
        do_txn(2'b10, 12'h300, 32'h0, 1'b0, 1'b1);
        chk("rs_src_zero_no_wr", raw_wr - b_wr, 0);
        chk("rs_src_zero_resp", last_resp, 32'hA);
        b_rd = raw_rd;
        do_txn(2'b01, 12'h300, 32'h55, 1'b1, 1'b0);
        chk("rw_rd_zero_no_rd", raw_rd - b_rd, 0);
        chk("rw_rd_zero_resp", last_resp, 32'h0);
        tick();
        chk("rw_rd_zero_value", file_mem[12'h300], 32'h55);

        // Two flag pulses merge into a single fcsr flush
        preload(FCSR, 32'h40);
        b_fl = raw_fl;
        tick(); bus.fflags_valid = 1'b1; bus.fflags = 5'h01;
        tick(); bus.fflags_valid = 1'b1; bus.fflags = 5'h04;
        chk("flags_block_ready", bus.req_ready, 0);
        tick();
        chk("flush_en", bus.fcsr_wr_en, 1);
        chk("flush_data", bus.fcsr_wr_data, 32'h45);
        tick();
        chk("ready_after_flush", bus.req_ready, 1);
        chk("single_flush", raw_fl - b_fl, 1);
        chk("fcsr_value", file_mem[FCSR], 32'h45);

        // Illegal op with a stalled consumer: response stays put, no CSR access
        b_rd = raw_rd; b_wr = raw_wr;
        rr_mode = 2;
        send_req(2'b00, 12'h340, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("ill_hold_valid", bus.resp_valid, 1);
            chk("ill_hold_data", bus.resp_data, 0);
            chk("ill_hold_flag", bus.resp_illegal, 1);
            tick();
        end
        rr_mode = 1;
        repeat (3) tick();
        chk("ill_no_enables", (raw_rd - b_rd) + (raw_wr - b_wr), 0);
        chk("ill_resp_flag", last_ill, 1);

        // Reset while in WRITE abandons the write
        preload(12'h340, 32'h11112222);
        b_wr = raw_wr;
        send_req(2'b01, 12'h340, 32'hCAFEF00D, 1'b0, 1'b0);
        tick();
        chk("pre_reset_in_write", bus.csr_wr_en, 1);
        RESET = 1'b0;
        #1 chk("mid_reset_outputs", outs(), 0);
        tick(); tick();
        RESET = 1'b1;
        tick();
        chk("post_reset_ready", bus.req_ready, 1);
        tick(); tick();
        chk("post_reset_no_write", raw_wr - b_wr, 0);
        chk("post_reset_value", file_mem[12'h340], 32'h11112222);

        // Randomized traffic with background flags and a jittery consumer
        for (int i = 0; i < 5; i++) preload(addrs[i], $urandom);
        rr_mode = 0; flag_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_txn(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 4)], $urandom,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end
        flag_en = 1'b0; rr_mode = 1;
        repeat (10) tick();
        for (int i = 0; i < 5; i++) chk("final_csr", file_mem[addrs[i]], ref_mem[addrs[i]]);
        chk("final_pending", mdl_pending, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_access_sequencer.md
Name: csr_access_sequencer

Overview:
- Sits directly upstream of the CSR register file and is the only block that drives its read and write ports.
- Turns each CSRRW/CSRRS/CSRRC request into a read phase, a modify-write phase and a response phase.
- Accumulates FPU exception flags and merges them into fcsr by read-modify-write.
- The CSR file reads combinationally (same cycle) and writes on the rising CLK edge.

Parameters:
- FCSR_INDEX, 3, CSR address of fcsr.
- FFLAGS_WIDTH, 5, width of the accrued-exception field in fcsr[4:0].

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  2  01=RW, 10=RS, 11=RC, 00=illegal
- req_csr  in  12  CSR address
- req_src  in  32  rs1 value or zimm
- req_rd_zero  in  1  rd==x0
- req_src_zero  in  1  rs1 field/zimm==0
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when valid&ready
- resp_data  out  32  old CSR value
- resp_illegal  out  1  op was 00
- fflags_valid  in  1  FPU flags pulse
- fflags  in  5  FPU flags
- csr_rd_en  out  1  to CSR file read enable
- csr_rd_sel  out  12  to CSR file read select
- csr_rd_data  in  32  from CSR file
- fcsr_rd_data  in  32  from CSR file fcsr output
- csr_wr_en  out  1  to CSR file write enable
- csr_wr_sel  out  12  to CSR file write select
- csr_wr_data  out  32  to CSR file write data
- fcsr_wr_en  out  1  to CSR file fcsr write enable
- fcsr_wr_data  out  32  to CSR file fcsr write data

Behaviour:
- States: IDLE, READ, WRITE, FLUSH, RESP.
- Reset (RESET=0, asynchronous):
  - state=IDLE; pending flags=0; captured request cleared.
  - Every output is 0, including req_ready, resp_valid, all enables, all selects and data.
  - Reset mid-operation abandons the operation; no write is issued after reset is released.
- IDLE:
  - req_ready=1 when pending==0; otherwise 0.
  - If pending!=0, go to FLUSH.
  - Else, on accept, register the request:
    - op==00: go to RESP with resp_illegal=1, resp_data=0.
    - RW with rd_zero: go to WRITE directly; no read; resp_data=0.
    - Otherwise: go to READ.
- READ (1 cycle):
  - csr_rd_en=1, csr_rd_sel=req_csr; capture csr_rd_data into old at the edge.
  - RS/RC with src_zero: go to RESP; no write.
  - Otherwise: go to WRITE.
- WRITE (1 cycle):
  - csr_wr_en=1, csr_wr_sel=req_csr.
  - csr_wr_data: RW = src; RS = old|src; RC = old&~src.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_illegal held stable until resp_ready.
  - On resp_ready go to IDLE; back-to-back requests need at least 1 IDLE cycle.
- FLUSH (1 cycle):
  - fcsr_wr_en=1; fcsr_wr_data = fcsr_rd_data | zero-extended pending.
  - pending cleared at the edge, except flags arriving that same cycle stay pending.
  - Go to IDLE.
- Flag accumulation: fflags_valid ORs fflags into pending in every state.
- Ordering: flags arriving in the same cycle a request is accepted are ordered after that request; they are flushed after its RESP.
- Outputs: csr_wr_en and fcsr_wr_en are never high in the same cycle. All enables are registered-state decodes, high only in their state.
- Widths: all CSR data is 32-bit, with no sign extension. Addresses are used unmodified; the CSR file handles fflags/frm aliasing.

Test Plan:
- Reset, then RW csr=0x340, src=0xDEADBEEF, rd_zero=0, CSR holds 0x12345678 -> READ then WRITE with wr_data=0xDEADBEEF; resp_data=0x12345678 on the 3rd cycle after accept.
- RS csr=0x300, src=0x8, CSR holds 0x3 -> wr_data=0xB, resp_data=0x3. Then RC with src=0x1 -> wr_data=0xA.
- RS with src_zero=1 -> no csr_wr_en pulse; resp_data=old. RW with rd_zero=1 -> no csr_rd_en pulse; resp_data=0.
- fflags_valid pulses with 0x01 then 0x04, fcsr_rd_data=0x40 -> req_ready=0, one FLUSH with fcsr_wr_data=0x45, then req_ready=1.
- op=00 -> resp_illegal=1, no enables asserted. Hold resp_ready=0 for 5 cycles -> resp_valid and data stable throughout.
- Assert RESET=0 during WRITE -> all outputs 0 immediately; after release, no write occurs and req_ready=1.
